// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the CPU/IO data-memory port arbiter.
// Owner codes tag each in-flight read so its data returns to the right requester.
package mem_arb_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      OWNER_NONE = 2'b00,
      OWNER_CPU  = 2'b01,
      OWNER_IO   = 2'b10
   } owner_e;

   // Writes never return data, so only a granted read gets a real owner.
   function automatic owner_e read_owner(input logic cpu_win,
                                         input logic io_win,
                                         input logic sel_we);
      owner_e o;
      o = OWNER_NONE;
      if (!sel_we) begin
         if (io_win)       o = OWNER_IO;
         else if (cpu_win) o = OWNER_CPU;
      end
      return o;
   endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive cycles the IO requester was denied.
// sat is high once the count reaches MAX; it holds there until cleared.
module arb_wait_counter #(
   parameter int MAX = 4
) (
   input  logic main_clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam int CW = $clog2(MAX + 1);
   localparam logic [CW-1:0] C_MAX = CW'(MAX);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge main_clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != C_MAX)) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign sat = (r_cnt == C_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port data memory between the CPU and the IO requester,
// registers the winning command and routes read data back with rvalid pulses.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int IO_MAX_WAIT = 4
) (
   input  logic              main_clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              io_req,
   input  logic              io_we,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [DATA_W-1:0] io_wdata,
   output logic              io_gnt,
   output logic              io_rvalid,
   output logic [DATA_W-1:0] io_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   logic              w_starve;
   logic              w_io_win;
   logic              w_cpu_win;
   logic              w_any_gnt;
   logic              w_io_inc;
   logic              w_io_clr;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   owner_e            w_rd_owner;

   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   owner_e            r_owner_s1;
   owner_e            r_owner_s2;

   arb_wait_counter #(
      .MAX (IO_MAX_WAIT)
   ) u_wait_counter (
      .main_clk (main_clk),
      .reset    (reset),
      .inc      (w_io_inc),
      .clr      (w_io_clr),
      .sat      (w_starve)
   );

   // CPU has priority except when IO has been denied long enough to starve.
   always_comb begin
      w_io_win    = io_req & (w_starve | ~cpu_req);
      w_cpu_win   = cpu_req & ~w_io_win;
      w_any_gnt   = w_cpu_win | w_io_win;
      w_sel_we    = w_io_win ? io_we    : cpu_we;
      w_sel_addr  = w_io_win ? io_addr  : cpu_addr;
      w_sel_wdata = w_io_win ? io_wdata : cpu_wdata;
      w_rd_owner  = read_owner(w_cpu_win, w_io_win, w_sel_we);
   end

   assign w_io_inc = io_req & ~w_io_win;
   assign w_io_clr = w_io_win | ~io_req;

   assign cpu_gnt   = w_cpu_win;
   assign io_gnt    = w_io_win;
   assign cpu_stall = cpu_req & ~w_cpu_win;

   // Address and write data hold across idle cycles; only the strobes drop.
   always_ff @(posedge main_clk or posedge reset) begin
      if (reset) begin
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else if (w_any_gnt) begin
         r_mem_en    <= 1'b1;
         r_mem_we    <= w_sel_we;
         r_mem_addr  <= w_sel_addr;
         r_mem_wdata <= w_sel_wdata;
      end else begin
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
      end
   end

   // Two stages match the command register plus the memory's read latency.
   always_ff @(posedge main_clk or posedge reset) begin
      if (reset) begin
         r_owner_s1 <= OWNER_NONE;
         r_owner_s2 <= OWNER_NONE;
      end else begin
         r_owner_s1 <= w_rd_owner;
         r_owner_s2 <= r_owner_s1;
      end
   end

   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

   assign cpu_rvalid = (r_owner_s2 == OWNER_CPU);
   assign io_rvalid  = (r_owner_s2 == OWNER_IO);
   assign cpu_rdata  = mem_rdata;
   assign io_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory, reference model and a
// read-data scoreboard, exercised by one task per scenario.
module tb_mem_port_arbiter;

   localparam int AW   = 10;
   localparam int DW   = 32;
   localparam int MAXW = 4;
   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_CPU  = 2'b01;
   localparam logic [1:0] OWN_IO   = 2'b10;

   // ---------------- clock / reset ----------------
   logic main_clk = 1'b0;
   logic reset;
   always #5 main_clk = ~main_clk;

   logic          cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          io_req, io_we, io_gnt, io_rvalid;
   logic [AW-1:0] io_addr;
   logic [DW-1:0] io_wdata, io_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   mem_port_arbiter #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .IO_MAX_WAIT (MAXW)
   ) dut (
      .main_clk   (main_clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_stall  (cpu_stall),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .io_req     (io_req),
      .io_we      (io_we),
      .io_addr    (io_addr),
      .io_wdata   (io_wdata),
      .io_gnt     (io_gnt),
      .io_rvalid  (io_rvalid),
      .io_rdata   (io_rdata),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // ---------------- counters, memories, model state ----------------
   int n_cmp  = 0;
   int n_fail = 0;

   logic [DW-1:0] mem_array [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem   [0:(1<<AW)-1];
   logic [DW-1:0] exp_q[$];

   int            m_cnt;
   logic [1:0]    m_s1, m_s2;
   logic          m_en, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;

   function automatic logic model_io_win();
      return io_req && ((m_cnt == MAXW) || !cpu_req);
   endfunction

   function automatic logic model_cpu_win();
      return cpu_req && !model_io_win();
   endfunction

   task automatic model_reset();
      m_cnt   = 0;
      m_s1    = OWN_NONE;
      m_s2    = OWN_NONE;
      m_en    = 1'b0;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      exp_q.delete();
   endtask

   task automatic drive_idle();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      io_req  = 1'b0; io_we  = 1'b0; io_addr  = '0; io_wdata  = '0;
   endtask

   // ---------------- clock step with scoreboard ----------------
   // Mid-cycle: compare the registered command and read return with the model
   // and pop expected read data. After the edge: advance memory and model.
   task automatic tick();
      logic          c_en, c_we, g_cpu, g_io, s_we, s_ioreq;
      logic [AW-1:0] c_addr, s_addr;
      logic [DW-1:0] c_wd, s_wd, exp_d, act_d;
      @(negedge main_clk);
      n_cmp++;
      if (mem_en !== m_en) begin
         n_fail++; $display("FAIL sb_mem_en actual=%b expected=%b t=%0t", mem_en, m_en, $time);
      end
      n_cmp++;
      if (mem_we !== m_we) begin
         n_fail++; $display("FAIL sb_mem_we actual=%b expected=%b t=%0t", mem_we, m_we, $time);
      end
      n_cmp++;
      if (mem_addr !== m_addr) begin
         n_fail++; $display("FAIL sb_mem_addr actual=%h expected=%h t=%0t", mem_addr, m_addr, $time);
      end
      n_cmp++;
      if (mem_wdata !== m_wdata) begin
         n_fail++; $display("FAIL sb_mem_wdata actual=%h expected=%h t=%0t", mem_wdata, m_wdata, $time);
      end
      n_cmp++;
      if (cpu_rvalid !== (m_s2 == OWN_CPU)) begin
         n_fail++; $display("FAIL sb_cpu_rvalid actual=%b expected=%b t=%0t", cpu_rvalid, (m_s2 == OWN_CPU), $time);
      end
      n_cmp++;
      if (io_rvalid !== (m_s2 == OWN_IO)) begin
         n_fail++; $display("FAIL sb_io_rvalid actual=%b expected=%b t=%0t", io_rvalid, (m_s2 == OWN_IO), $time);
      end
      if (m_s2 != OWN_NONE) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL sb_underflow actual=empty expected=entry t=%0t", $time);
         end else begin
            exp_d = exp_q.pop_front();
            act_d = (m_s2 == OWN_CPU) ? cpu_rdata : io_rdata;
            if (act_d !== exp_d) begin
               n_fail++; $display("FAIL sb_rdata owner=%0d actual=%h expected=%h t=%0t", m_s2, act_d, exp_d, $time);
            end
         end
      end
      c_en = mem_en; c_we = mem_we; c_addr = mem_addr; c_wd = mem_wdata;
      g_io    = !reset && model_io_win();
      g_cpu   = !reset && model_cpu_win();
      s_we    = g_io ? io_we    : cpu_we;
      s_addr  = g_io ? io_addr  : cpu_addr;
      s_wd    = g_io ? io_wdata : cpu_wdata;
      s_ioreq = io_req;
      @(posedge main_clk);
      if (c_en) begin
         if (c_we) mem_array[c_addr] = c_wd;
         else      mem_rdata = mem_array[c_addr];
      end
      if (reset) begin
         model_reset();
      end else begin
         m_s2 = m_s1;
         m_s1 = OWN_NONE;
         if (g_cpu || g_io) begin
            m_en = 1'b1; m_we = s_we; m_addr = s_addr; m_wdata = s_wd;
            if (s_we) begin
               ref_mem[s_addr] = s_wd;
            end else begin
               m_s1 = g_io ? OWN_IO : OWN_CPU;
               exp_q.push_back(ref_mem[s_addr]);
            end
         end else begin
            m_en = 1'b0; m_we = 1'b0;
         end
         if (s_ioreq && !g_io) m_cnt = (m_cnt == MAXW) ? MAXW : m_cnt + 1;
         else                  m_cnt = 0;
      end
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      n_cmp++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
         n_fail++; $display("FAIL rst_mem actual=%b/%b/%h/%h expected=0", mem_en, mem_we, mem_addr, mem_wdata);
      end
      n_cmp++;
      if ({cpu_rvalid, io_rvalid} !== 2'b00) begin
         n_fail++; $display("FAIL rst_rvalid actual=%b%b expected=00", cpu_rvalid, io_rvalid);
      end
      cpu_req = 1'b1; io_req = 1'b1;
      #1;
      n_cmp++;
      if ({cpu_gnt, io_gnt, cpu_stall} !== 3'b100) begin
         n_fail++; $display("FAIL rst_gnt_both actual=%b expected=100", {cpu_gnt, io_gnt, cpu_stall});
      end
      cpu_req = 1'b0;
      #1;
      n_cmp++;
      if ({cpu_gnt, io_gnt} !== 2'b01) begin
         n_fail++; $display("FAIL rst_gnt_io actual=%b expected=01", {cpu_gnt, io_gnt});
      end
      tick();
      n_cmp++;
      if (mem_en !== 1'b0) begin
         n_fail++; $display("FAIL rst_no_issue actual=%b expected=0", mem_en);
      end
      drive_idle();
      reset = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_reset_mid_read();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(5);
      #1;
      n_cmp++;
      if (cpu_gnt !== 1'b1) begin
         n_fail++; $display("FAIL midrst_gnt actual=%b expected=1", cpu_gnt);
      end
      tick();
      cpu_req = 1'b0;
      reset = 1'b1;
      model_reset();
      #1;
      n_cmp++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
         n_fail++; $display("FAIL midrst_mem actual=%b/%b/%h/%h expected=0", mem_en, mem_we, mem_addr, mem_wdata);
      end
      tick();
      n_cmp++;
      if ({cpu_rvalid, io_rvalid} !== 2'b00) begin
         n_fail++; $display("FAIL midrst_rvalid actual=%b%b expected=00", cpu_rvalid, io_rvalid);
      end
      reset = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_cpu_read();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(5);
      #1;
      n_cmp++;
      if ({cpu_gnt, io_gnt, cpu_stall} !== 3'b100) begin
         n_fail++; $display("FAIL cpurd_gnt actual=%b expected=100", {cpu_gnt, io_gnt, cpu_stall});
      end
      tick();
      cpu_req = 1'b0;
      n_cmp++;
      if ({mem_en, mem_we, mem_addr, io_rvalid} !== {1'b1, 1'b0, AW'(5), 1'b0}) begin
         n_fail++; $display("FAIL cpurd_cmd actual=%b/%b/%h io_rv=%b expected=1/0/005 io_rv=0", mem_en, mem_we, mem_addr, io_rvalid);
      end
      tick();
      n_cmp++;
      if ({cpu_rvalid, io_rvalid, cpu_rdata} !== {2'b10, 32'hDEADBEEF}) begin
         n_fail++; $display("FAIL cpurd_ret actual=%b%b/%h expected=10/deadbeef", cpu_rvalid, io_rvalid, cpu_rdata);
      end
      repeat (2) tick();
   endtask

   task automatic test_starve();
      logic exp_io;
      io_req = 1'b1; io_we = 1'b0; io_addr = AW'($urandom_range(0, 1023));
      for (int k = 0; k < 20; k++) begin
         cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'($urandom_range(0, 1023));
         exp_io = ((k % 5) == 4);
         #1;
         n_cmp++;
         if ({cpu_gnt, io_gnt, cpu_stall} !== {!exp_io, exp_io, exp_io}) begin
            n_fail++; $display("FAIL starve_k%0d actual=%b expected=%b", k, {cpu_gnt, io_gnt, cpu_stall}, {!exp_io, exp_io, exp_io});
         end
         tick();
         if (exp_io) io_addr = AW'($urandom_range(0, 1023));
      end
      drive_idle();
      repeat (3) tick();
   endtask

   task automatic test_io_raw();
      io_req = 1'b1; io_we = 1'b1; io_addr = AW'(10'h3FF); io_wdata = 32'h12345678;
      #1;
      n_cmp++;
      if (io_gnt !== 1'b1) begin
         n_fail++; $display("FAIL raw_wr_gnt actual=%b expected=1", io_gnt);
      end
      tick();
      io_we = 1'b0;
      #1;
      n_cmp++;
      if (io_gnt !== 1'b1) begin
         n_fail++; $display("FAIL raw_rd_gnt actual=%b expected=1", io_gnt);
      end
      tick();
      drive_idle();
      tick();
      n_cmp++;
      if ({io_rvalid, cpu_rvalid, io_rdata} !== {2'b10, 32'h12345678}) begin
         n_fail++; $display("FAIL raw_ret actual=%b%b/%h expected=10/12345678", io_rvalid, cpu_rvalid, io_rdata);
      end
      repeat (2) tick();
   endtask

   task automatic test_alternate();
      for (int k = 0; k < 12; k++) begin
         drive_idle();
         if ((k % 2) == 0) begin
            cpu_req = 1'b1; cpu_addr = AW'($urandom_range(0, 1023));
         end else begin
            io_req = 1'b1; io_addr = AW'($urandom_range(0, 1023));
         end
         #1;
         n_cmp++;
         if ({cpu_gnt, io_gnt} !== {cpu_req, io_req}) begin
            n_fail++; $display("FAIL alt_gnt_k%0d actual=%b expected=%b", k, {cpu_gnt, io_gnt}, {cpu_req, io_req});
         end
         tick();
      end
      drive_idle();
      repeat (3) tick();
   endtask

   task automatic test_drop_restart();
      // cycles 0-2 denied, 3 IO absent, 4-7 denied again, 8 IO wins
      for (int k = 0; k < 9; k++) begin
         cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'($urandom_range(0, 1023));
         io_req  = (k != 3); io_we = 1'b0; io_addr = AW'(10'h155);
         #1;
         n_cmp++;
         if ({cpu_gnt, io_gnt} !== ((k == 8) ? 2'b01 : 2'b10)) begin
            n_fail++; $display("FAIL drop_k%0d actual=%b expected=%b", k, {cpu_gnt, io_gnt}, (k == 8) ? 2'b01 : 2'b10);
         end
         tick();
      end
      drive_idle();
      repeat (3) tick();
   endtask

   task automatic test_back_to_back();
      logic exp_c, exp_i;
      for (int k = 0; k < 60; k++) begin
         if (!cpu_req && ($urandom_range(0, 3) != 0)) begin
            cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = AW'($urandom_range(0, 15)); cpu_wdata = $urandom;
         end
         if (!io_req && ($urandom_range(0, 2) != 0)) begin
            io_req = 1'b1; io_we = 1'($urandom_range(0, 1));
            io_addr = AW'($urandom_range(0, 15)); io_wdata = $urandom;
         end
         #1;
         exp_c = model_cpu_win();
         exp_i = model_io_win();
         n_cmp++;
         if ({cpu_gnt, io_gnt, cpu_stall} !== {exp_c, exp_i, cpu_req && !exp_c}) begin
            n_fail++; $display("FAIL b2b_gnt_k%0d actual=%b expected=%b", k, {cpu_gnt, io_gnt, cpu_stall}, {exp_c, exp_i, cpu_req && !exp_c});
         end
         tick();
         if (exp_c) cpu_req = 1'b0;
         if (exp_i) io_req = 1'b0;
      end
      drive_idle();
      repeat (4) tick();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL sb_drain actual=%0d expected=0", exp_q.size());
      end
   endtask

   // ---------------- main sequence and report ----------------
   initial begin
      logic [DW-1:0] v;
      reset = 1'b1;
      drive_idle();
      mem_rdata = '0;
      for (int i = 0; i < (1 << AW); i++) begin
         v = $urandom;
         mem_array[i] = v;
         ref_mem[i]   = v;
      end
      mem_array[5] = 32'hDEADBEEF;
      ref_mem[5]   = 32'hDEADBEEF;
      model_reset();
      repeat (2) @(posedge main_clk);
      #1;
      test_reset();
      test_reset_mid_read();
      test_cpu_read();
      test_starve();
      test_io_raw();
      test_alternate();
      test_drop_restart();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
